// File: rtl/control_unit_fsm.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_fsm
// Purpose  : Multi-cycle control unit for the single-bus datapath.
//            Sequences Init -> Fetch -> Decode -> Execute and drives every
//            datapath control line. The outputs are Moore-decoded from the
//            current state and the instruction register fields.
// Options  : CU_ILLEGAL_TRAP_EN -- when defined, an illegal opcode traps to
//            Halt and sets the sticky Illegal flag. When it is not defined,
//            an illegal opcode runs as Noop and Illegal is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit_fsm #(
    parameter int IW        = 16,
    parameter int OPW       = 4,
    parameter int RAW       = 4,
    parameter int DAW       = 8,
    parameter int ALUW      = 3,
    parameter int LOAD_WAIT = 1
) (
    input  logic            Clk,
    input  logic            ResetN,
    input  logic [IW-1:0]   IR,
    input  logic            Resume,
    output logic            PC_clr,
    output logic            PC_up,
    output logic            PC_ld,
    output logic [DAW-1:0]  Jmp_addr,
    output logic            IR_ld,
    output logic [DAW-1:0]  D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [RAW-1:0]  RF_W_addr,
    output logic [RAW-1:0]  RF_Ra_addr,
    output logic [RAW-1:0]  RF_Rb_addr,
    output logic [ALUW-1:0] Alu_s0,
    output logic            Halted,
    output logic            Illegal,
    output logic [3:0]      StateOut
);

    // State encoding
    localparam logic [3:0] c_INIT   = 4'd0;
    localparam logic [3:0] c_FETCH  = 4'd1;
    localparam logic [3:0] c_DECODE = 4'd2;
    localparam logic [3:0] c_NOOP   = 4'd3;
    localparam logic [3:0] c_STORE  = 4'd4;
    localparam logic [3:0] c_LOAD_A = 4'd5;
    localparam logic [3:0] c_LOAD_B = 4'd6;
    localparam logic [3:0] c_ADD    = 4'd7;
    localparam logic [3:0] c_SUB    = 4'd8;
    localparam logic [3:0] c_HALT   = 4'd9;
    localparam logic [3:0] c_JUMP   = 4'd10;

    // Opcode encoding
    localparam logic [OPW-1:0] c_OP_NOOP  = OPW'(0);
    localparam logic [OPW-1:0] c_OP_STORE = OPW'(1);
    localparam logic [OPW-1:0] c_OP_LOAD  = OPW'(2);
    localparam logic [OPW-1:0] c_OP_ADD   = OPW'(3);
    localparam logic [OPW-1:0] c_OP_SUB   = OPW'(4);
    localparam logic [OPW-1:0] c_OP_HALT  = OPW'(5);
    localparam logic [OPW-1:0] c_OP_JMP   = OPW'(6);

    // Last value the wait counter reaches before Load_A hands over to Load_B
    localparam logic [3:0] c_WAIT_LAST = 4'(LOAD_WAIT - 1);

    // Instruction fields. MA overlaps the A/B register fields by design.
    logic [OPW-1:0] w_op;
    logic [RAW-1:0] w_a;
    logic [RAW-1:0] w_b;
    logic [RAW-1:0] w_w;
    logic [DAW-1:0] w_ma;
    logic [DAW-1:0] w_sa;

    assign w_op = IR[IW-1 -: OPW];
    assign w_a  = IR[IW-OPW-1 -: RAW];
    assign w_b  = IR[IW-OPW-RAW-1 -: RAW];
    assign w_w  = IR[RAW-1:0];
    assign w_ma = IR[IW-OPW-1 -: DAW];
    assign w_sa = IR[DAW-1:0];

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // State and wait-counter registers. Reset aborts the instruction at once.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= c_INIT;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The counter counts only while in Load_A, so every
    // entry into Load_A from Decode starts the count at zero.
    always_comb begin
        state_d = c_INIT;
        cnt_d   = (state_q == c_LOAD_A) ? cnt_q + 4'd1 : 4'd0;
        case (state_q)
            c_INIT:   state_d = c_FETCH;
            c_FETCH:  state_d = c_DECODE;
            c_DECODE: begin
                case (w_op)
                    c_OP_NOOP:  state_d = c_NOOP;
                    c_OP_STORE: state_d = c_STORE;
                    c_OP_LOAD:  state_d = c_LOAD_A;
                    c_OP_ADD:   state_d = c_ADD;
                    c_OP_SUB:   state_d = c_SUB;
                    c_OP_HALT:  state_d = c_HALT;
                    c_OP_JMP:   state_d = c_JUMP;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_d = c_HALT;
`else
                        state_d = c_NOOP;
`endif
                    end
                endcase
            end
            c_NOOP:   state_d = c_FETCH;
            c_STORE:  state_d = c_FETCH;
            c_LOAD_A: state_d = (cnt_q == c_WAIT_LAST) ? c_LOAD_B : c_LOAD_A;
            c_LOAD_B: state_d = c_FETCH;
            c_ADD:    state_d = c_FETCH;
            c_SUB:    state_d = c_FETCH;
            c_HALT:   state_d = Resume ? c_FETCH : c_HALT;
            c_JUMP:   state_d = c_FETCH;
            default:  state_d = c_INIT;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_d;

    // Sticky illegal-opcode flag, set on decode of an opcode above JMP.
    always_comb begin
        illegal_d = illegal_q | ((state_q == c_DECODE) && (w_op > c_OP_JMP));
    end

    // Illegal flag register. Only reset clears it; Resume leaves it set.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    assign StateOut = state_q;

    // Moore output decode. Any output not driven in a state stays 0.
    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        PC_ld      = 1'b0;
        Jmp_addr   = '0;
        IR_ld      = 1'b0;
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_W_addr  = '0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        Alu_s0     = '0;
        Halted     = 1'b0;
        case (state_q)
            c_INIT:  PC_clr = 1'b1;
            c_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            c_STORE: begin
                D_Addr     = w_sa;
                D_Wr       = 1'b1;
                RF_Ra_addr = w_a;
            end
            c_LOAD_A: begin
                D_Addr    = w_ma;
                RF_s      = 1'b1;
                RF_W_addr = w_w;
            end
            c_LOAD_B: begin
                D_Addr    = w_ma;
                RF_s      = 1'b1;
                RF_W_addr = w_w;
                RF_W_en   = 1'b1;
            end
            c_ADD, c_SUB: begin
                RF_Ra_addr = w_a;
                RF_Rb_addr = w_b;
                RF_W_addr  = w_w;
                RF_W_en    = 1'b1;
                Alu_s0     = (state_q == c_ADD) ? ALUW'(1) : ALUW'(2);
            end
            c_JUMP: begin
                PC_ld    = 1'b1;
                Jmp_addr = w_sa;
            end
            c_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit_fsm
// Purpose  : Directed self-checking bench for control_unit_fsm (LOAD_WAIT=3).
//            Each check compares the full concatenated output bundle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit_fsm;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic [15:0] IR;
    logic        Resume;
    logic        PC_clr, PC_up, PC_ld, IR_ld, D_Wr, RF_s, RF_W_en, Halted, Illegal;
    logic [7:0]  Jmp_addr, D_Addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, StateOut;
    logic [2:0]  Alu_s0;

    int n_vec = 0;
    int n_err = 0;
    logic exp_ill = 1'b0;

    control_unit_fsm #(
        .IW(16), .OPW(4), .RAW(4), .DAW(8), .ALUW(3), .LOAD_WAIT(3)
    ) dut (
        .Clk(Clk), .ResetN(ResetN), .IR(IR), .Resume(Resume),
        .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld), .Jmp_addr(Jmp_addr),
        .IR_ld(IR_ld), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
        .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
        .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0), .Halted(Halted),
        .Illegal(Illegal), .StateOut(StateOut)
    );

    always #5 Clk = ~Clk;

    // Observed bundle: state, PC_clr, PC_up, PC_ld, Jmp_addr, IR_ld, D_Addr,
    // D_Wr, RF_s, RF_W_en, W, Ra, Rb, Alu, Halted, Illegal (44 bits)
    logic [43:0] obs;
    assign obs = {StateOut, PC_clr, PC_up, PC_ld, Jmp_addr, IR_ld, D_Addr,
                  D_Wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr,
                  Alu_s0, Halted, Illegal};

    function automatic logic [43:0] mk(
        input logic [3:0] st, input logic clr, input logic up, input logic ld,
        input logic [7:0] ja, input logic irld, input logic [7:0] da,
        input logic wr, input logic s, input logic wen, input logic [3:0] wa,
        input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu,
        input logic hlt, input logic ill);
        return {st, clr, up, ld, ja, irld, da, wr, s, wen, wa, ra, rb, alu, hlt, ill};
    endfunction

    // Active edge then a small settle delay; inputs change here too
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [43:0] e;
        ResetN = 1'b0; IR = 16'h3123; Resume = 1'b0;
        #12;
        e = mk(4'd0,1,0,0,8'h00,0,8'h00,0,0,0,4'h0,4'h0,4'h0,3'd0,0,0);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL reset_state obs=%h exp=%h", obs, e); end
        @(negedge Clk); ResetN = 1'b1;
        step();
        e = mk(4'd1,0,1,0,8'h00,1,8'h00,0,0,0,4'h0,4'h0,4'h0,3'd0,0,0);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL first_fetch obs=%h exp=%h", obs, e); end
        step();
        e = mk(4'd2,0,0,0,8'h00,0,8'h00,0,0,0,4'h0,4'h0,4'h0,3'd0,0,0);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL decode obs=%h exp=%h", obs, e); end
        step();
        e = mk(4'd7,0,0,0,8'h00,0,8'h00,0,0,1,4'h3,4'h1,4'h2,3'd1,0,0);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL add obs=%h exp=%h", obs, e); end
        step();
        e = mk(4'd1,0,1,0,8'h00,1,8'h00,0,0,0,4'h0,4'h0,4'h0,3'd0,0,0);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL add_to_fetch obs=%h exp=%h", obs, e); end
    endtask

    // Entered in Fetch; leaves in Fetch
    task automatic test_load();
        logic [43:0] e;
        IR = 16'h2A57;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            e = mk(4'd5,0,0,0,8'h00,0,8'hA5,0,1,0,4'h7,4'h0,4'h0,3'd0,0,exp_ill);
            n_vec++; if (obs !== e) begin n_err++; $display("FAIL load_a[%0d] obs=%h exp=%h", i, obs, e); end
            step();
        end
        e = mk(4'd6,0,0,0,8'h00,0,8'hA5,0,1,1,4'h7,4'h0,4'h0,3'd0,0,exp_ill);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL load_b obs=%h exp=%h", obs, e); end
        step();
        n_vec++; if (StateOut !== 4'd1) begin n_err++; $display("FAIL load_to_fetch state=%0d exp=1", StateOut); end
    endtask

    task automatic test_store();
        logic [43:0] e;
        IR = 16'h1C4E;
        step(); step();
        e = mk(4'd4,0,0,0,8'h00,0,8'h4E,1,0,0,4'h0,4'hC,4'h0,3'd0,0,exp_ill);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL store obs=%h exp=%h", obs, e); end
        step();
        n_vec++; if (StateOut !== 4'd1) begin n_err++; $display("FAIL store_to_fetch state=%0d exp=1", StateOut); end
    endtask

    task automatic test_sub();
        logic [43:0] e;
        IR = 16'h49B5;
        step(); step();
        e = mk(4'd8,0,0,0,8'h00,0,8'h00,0,0,1,4'h5,4'h9,4'hB,3'd2,0,exp_ill);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL sub obs=%h exp=%h", obs, e); end
        step();
    endtask

    task automatic test_jump();
        logic [43:0] e;
        IR = 16'h60F0;
        step(); step();
        e = mk(4'd10,0,0,1,8'hF0,0,8'h00,0,0,0,4'h0,4'h0,4'h0,3'd0,0,exp_ill);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL jump obs=%h exp=%h", obs, e); end
        step();
        n_vec++; if (StateOut !== 4'd1) begin n_err++; $display("FAIL jump_to_fetch state=%0d exp=1", StateOut); end
    endtask

    task automatic test_noop();
        IR = 16'h0FFF;
        Resume = 1'b1;   // ignored outside Halt
        step(); step();
        n_vec++; if (StateOut !== 4'd3) begin n_err++; $display("FAIL noop state=%0d exp=3", StateOut); end
        Resume = 1'b0;
        step();
        n_vec++; if (StateOut !== 4'd1) begin n_err++; $display("FAIL noop_to_fetch state=%0d exp=1", StateOut); end
    endtask

    task automatic test_halt();
        logic [43:0] e;
        IR = 16'h5000;
        step(); step();
        e = mk(4'd9,0,0,0,8'h00,0,8'h00,0,0,0,4'h0,4'h0,4'h0,3'd0,1,exp_ill);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (obs !== e) begin n_err++; $display("FAIL halt[%0d] obs=%h exp=%h", i, obs, e); end
            if (i < 4) step();
        end
        Resume = 1'b1;
        step();
        Resume = 1'b0;
        n_vec++; if ({StateOut, Halted} !== {4'd1, 1'b0}) begin
            n_err++; $display("FAIL halt_resume state=%0d halted=%b exp=1/0", StateOut, Halted); end
    endtask

    // Resume already high when Halt is entered: exactly one Halt cycle
    task automatic test_resume_held();
        IR = 16'h5000;
        step();
        Resume = 1'b1;
        step();
        n_vec++; if ({StateOut, Halted} !== {4'd9, 1'b1}) begin
            n_err++; $display("FAIL held_halt state=%0d halted=%b exp=9/1", StateOut, Halted); end
        step();
        Resume = 1'b0;
        n_vec++; if (StateOut !== 4'd1) begin n_err++; $display("FAIL held_exit state=%0d exp=1", StateOut); end
    endtask

    task automatic test_illegal();
        IR = 16'hE000;
        step(); step();
`ifdef CU_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
        n_vec++; if ({StateOut, Halted, Illegal} !== {4'd9, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL illegal_trap state=%0d halted=%b ill=%b exp=9/1/1", StateOut, Halted, Illegal); end
        Resume = 1'b1;
        step();
        Resume = 1'b0;
        n_vec++; if ({StateOut, Illegal} !== {4'd1, 1'b1}) begin
            n_err++; $display("FAIL illegal_sticky state=%0d ill=%b exp=1/1", StateOut, Illegal); end
`else
        n_vec++; if ({StateOut, Illegal} !== {4'd3, 1'b0}) begin
            n_err++; $display("FAIL illegal_noop state=%0d ill=%b exp=3/0", StateOut, Illegal); end
        step();
        n_vec++; if (StateOut !== 4'd1) begin n_err++; $display("FAIL illegal_to_fetch state=%0d exp=1", StateOut); end
`endif
    endtask

    // Asynchronous reset in the middle of Load_A
    task automatic test_reset_mid_load();
        logic [43:0] e;
        IR = 16'h2A57;
        step(); step(); step();
        n_vec++; if (StateOut !== 4'd5) begin n_err++; $display("FAIL mid_load_pre state=%0d exp=5", StateOut); end
        #2;
        ResetN = 1'b0;
        exp_ill = 1'b0;
        #1;
        e = mk(4'd0,1,0,0,8'h00,0,8'h00,0,0,0,4'h0,4'h0,4'h0,3'd0,0,0);
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL async_reset obs=%h exp=%h", obs, e); end
        @(negedge Clk); @(negedge Clk);
        ResetN = 1'b1;
        step();
        n_vec++; if (StateOut !== 4'd1) begin n_err++; $display("FAIL post_reset_fetch state=%0d exp=1", StateOut); end
        // Fresh load after the abort must again spend exactly three Load_A cycles
        step(); step(); step(); step();
        n_vec++; if ({StateOut, RF_W_en} !== {4'd5, 1'b0}) begin
            n_err++; $display("FAIL reload_last_a state=%0d wen=%b exp=5/0", StateOut, RF_W_en); end
        step();
        n_vec++; if ({StateOut, RF_W_en} !== {4'd6, 1'b1}) begin
            n_err++; $display("FAIL reload_b state=%0d wen=%b exp=6/1", StateOut, RF_W_en); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_sub();
        test_jump();
        test_noop();
        test_halt();
        test_resume_held();
        test_illegal();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
